// File: rtl/acc_drain_activation_if.sv
// Accumulator-drain interface: job control, accumulator read port and output row stream.
// master = drain engine, slave = job issuer / accumulator / unified-buffer side.
interface acc_drain_activation_if #(
  parameter int DATA_SIZE  = 20,
  parameter int DATA_NUM   = 16,
  parameter int OUT_SIZE   = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                          start;
  logic [ADDR_WIDTH-1:0]         base_addr;
  logic [ADDR_WIDTH:0]           row_count;
  logic [4:0]                    shift;
  logic                          relu_en;
  logic                          busy;
  logic                          done;
  logic                          acc_enb;
  logic [ADDR_WIDTH-1:0]         acc_addrb;
  logic [DATA_NUM*DATA_SIZE-1:0] acc_doutb;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_NUM*OUT_SIZE-1:0]  out_data;
  logic                          out_last;

  modport master (
    input  start, base_addr, row_count, shift, relu_en, acc_doutb, out_ready,
    output busy, done, acc_enb, acc_addrb, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, row_count, shift, relu_en, acc_doutb, out_ready,
    input  busy, done, acc_enb, acc_addrb, out_valid, out_data, out_last
  );
endinterface

// File: rtl/acc_drain_activation.sv
// Drains accumulator rows, requantizes each lane to 8 bits (round, ReLU, saturate) and streams rows out.
// First row valid 2 cycles after the first read; reads are throttled so the 2-entry queue never overflows.
module acc_drain_activation #(
  parameter int DATA_SIZE  = 20,
  parameter int DATA_NUM   = 16,
  parameter int OUT_SIZE   = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  acc_drain_activation_if.master bus
);

  localparam logic signed [DATA_SIZE:0] SAT_MAX = (DATA_SIZE+1)'((1 << (OUT_SIZE-1)) - 1);
  localparam logic signed [DATA_SIZE:0] SAT_MIN = (DATA_SIZE+1)'(-(1 << (OUT_SIZE-1)));
  localparam logic [ADDR_WIDTH:0]       CNT_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state;
  logic                         busy_q, done_q;
  logic [ADDR_WIDTH-1:0]        base_q;
  logic [ADDR_WIDTH:0]          count_q, issued_q;
  logic [4:0]                   shift_q;
  logic                         relu_q;
  logic                         enb_q, last_q;
  logic [DATA_NUM*OUT_SIZE-1:0] mem_dat [2];
  logic                         mem_last [2];
  logic                         rd_ptr, wr_ptr;
  logic [1:0]                   occ;
  logic                         pop, rd_en, last_rd;
  logic [DATA_NUM*OUT_SIZE-1:0] req_dat;

  // Rounding arithmetic shift in DATA_SIZE+1 bits so the rounding add cannot overflow.
  function automatic logic [OUT_SIZE-1:0] requant(input logic signed [DATA_SIZE-1:0] x,
                                                  input logic [4:0] sh, input logic relu);
    logic signed [DATA_SIZE:0] y;
    y = {x[DATA_SIZE-1], x};
    if (sh != 5'd0)
      y = (y + ((DATA_SIZE+1)'(1) <<< (sh - 5'd1))) >>> sh;
    if (relu && y[DATA_SIZE])
      y = '0;
    if (y > SAT_MAX)
      y = SAT_MAX;
    else if (y < SAT_MIN)
      y = SAT_MIN;
    return y[OUT_SIZE-1:0];
  endfunction

  always_comb begin
    req_dat = '0;
    for (int i = 0; i < DATA_NUM; i++)
      req_dat[i*OUT_SIZE +: OUT_SIZE] = requant(bus.acc_doutb[i*DATA_SIZE +: DATA_SIZE], shift_q, relu_q);
  end

  assign pop     = bus.out_valid & bus.out_ready;
  assign last_rd = (issued_q == count_q - CNT_ONE);
  // Count the read already in flight so its row always has a free slot on arrival.
  assign rd_en   = (state == RUN) && (({1'b0, occ} + {2'b0, enb_q} - {2'b0, pop}) < 3'd2);

  assign bus.acc_enb   = rd_en;
  assign bus.acc_addrb = base_q + issued_q[ADDR_WIDTH-1:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = bus.out_valid ? mem_dat[rd_ptr] : '0;
  assign bus.out_last  = bus.out_valid & mem_last[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          base_q   <= bus.base_addr;
          count_q  <= bus.row_count;
          shift_q  <= bus.shift;
          relu_q   <= bus.relu_en;
          issued_q <= '0;
          if (bus.row_count == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: if (rd_en) begin
          issued_q <= issued_q + CNT_ONE;
          if (last_rd)
            state <= DRAIN;
        end
        DRAIN: if (pop && bus.out_last) begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enb_q  <= 1'b0;
      last_q <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_dat[i]  <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      enb_q  <= rd_en;
      last_q <= rd_en & last_rd;
      if (enb_q) begin
        mem_dat[wr_ptr]  <= req_dat;
        mem_last[wr_ptr] <= last_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({enb_q, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_drain_activation.sv
// Randomized bench for acc_drain_activation against a plain-arithmetic row model and scoreboard.
module tb_acc_drain_activation;
  localparam int DS = 20, DN = 16, OS = 8, AW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  acc_drain_activation_if #(.DATA_SIZE(DS), .DATA_NUM(DN), .OUT_SIZE(OS), .ADDR_WIDTH(AW)) bus ();

  acc_drain_activation #(.DATA_SIZE(DS), .DATA_NUM(DN), .OUT_SIZE(OS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DS-1:0]      mem [16][DN];
  int                 exp_addr [$];
  logic [DN*OS-1:0]   exp_dat [$];
  bit                 exp_last [$];
  int                 reads = 0, pops = 0, job_pops = 0;
  int                 rdy_mode = 0;
  bit                 prev_stall = 0;
  logic [DN*OS:0]     prev_word;
  logic [DN*OS-1:0]   first_row;

  task automatic check(string name, logic [135:0] act, logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference requantization: floor division by 2^shift after adding half an LSB.
  function automatic int rq(int x, int sh, bit relu);
    int y;
    if (sh > 0) y = int'($floor(real'(x + (1 << (sh - 1))) / real'(1 << sh)));
    else        y = x;
    if (relu && y < 0) y = 0;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  // Accumulator memory: one-cycle read latency.
  always @(posedge clk)
    if (bus.acc_enb)
      for (int l = 0; l < DN; l++) bus.acc_doutb[l*DS +: DS] <= mem[bus.acc_addrb][l];

  initial begin
    int phase;
    phase = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (phase == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      phase = (phase + 1) % 3;
    end
  end

  // Scoreboard: handshakes, read addresses, stall stability, queue bound.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", {bus.out_last, bus.out_data}, prev_word);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_dat.size() == 0) check("extra_row", 1, 0);
        else begin
          if (job_pops == 0) first_row = bus.out_data;
          check("out_data", bus.out_data, exp_dat.pop_front());
          check("out_last", bus.out_last, exp_last.pop_front());
        end
        pops++;
        job_pops++;
      end
      if (bus.acc_enb) begin
        if (exp_addr.size() == 0) check("extra_read", 1, 0);
        else check("acc_addrb", bus.acc_addrb, exp_addr.pop_front());
        reads++;
        check("queue_bound", (reads - pops) <= 2, 1);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_last, bus.out_data};
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_acc_enb"}, bus.acc_enb, 0);
    check({tag, "_acc_addrb"}, bus.acc_addrb, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
  endtask

  task automatic run_job(int base, int n, int sh, bit relu, int t_exp, bit poke, int abort_at);
    int cyc;
    bit seen;
    for (int r = 0; r < n; r++) begin
      int a;
      logic [DN*OS-1:0] row;
      a = (base + r) % 16;
      exp_addr.push_back(a);
      for (int l = 0; l < DN; l++) begin
        int v;
        v = rq($signed(mem[a][l]), sh, relu);
        row[l*OS +: OS] = v[7:0];
      end
      exp_dat.push_back(row);
      exp_last.push_back(r == n - 1);
    end
    job_pops = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = AW'(base); bus.row_count = (AW+1)'(n);
    bus.shift = 5'(sh); bus.relu_en = relu;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check("busy_cycle1", bus.busy, (n > 0));
    seen = 0;
    while (cyc < 400 && !seen) begin
      if (abort_at > 0 && job_pops >= abort_at) begin
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midjob_reset");
        exp_addr.delete(); exp_dat.delete(); exp_last.delete();
        prev_stall = 0; reads = 0; pops = 0;
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (bus.done) seen = 1;
      else begin
        if (poke && cyc == 4) begin
          bus.start = 1'b1; bus.base_addr = 4'd9; bus.row_count = 5'd3;
        end else if (poke && cyc == 5) bus.start = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", seen, 1);
    check("busy_at_done", bus.busy, 0);
    if (t_exp > 0) check("done_cycle", cyc, t_exp);
    if (poke) begin
      bus.start = 1'b1; bus.row_count = 5'd5;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_at_done_ignored", bus.busy, 0);
    end
    @(negedge clk);
    check("rows_left", exp_dat.size(), 0);
    check("reads_left", exp_addr.size(), 0);
    check("done_one_cycle", bus.done, 0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 16; a++)
      for (int l = 0; l < DN; l++) mem[a][l] = DS'($urandom);
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.row_count = '0; bus.shift = '0; bus.relu_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    check("model_24", rq(24, 4, 1), 2);
    check("model_23", rq(23, 4, 1), 1);
    check("model_m24_relu", rq(-24, 4, 1), 0);
    check("model_m24", rq(-24, 4, 0), -1);
    check("model_sat", rq(300000, 4, 1), 127);
    check("model_noshift", rq(-3, 0, 0), -3);

    for (int a = 0; a < 16; a++)
      for (int l = 0; l < DN; l++) mem[a][l] = (l % 2 == 0) ? DS'(5) : DS'(-3);
    rdy_mode = 0;
    run_job(0, 16, 0, 0, 19, 0, 0);
    check("lit_lanes_5_m3", first_row[15:0], 16'hFD05);

    fill_random();
    run_job(14, 4, 3, 0, 7, 0, 0);

    for (int a = 0; a < 16; a++)
      for (int l = 0; l < DN; l++)
        case (l % 4)
          0: mem[a][l] = DS'(24);
          1: mem[a][l] = DS'(23);
          2: mem[a][l] = DS'(-24);
          default: mem[a][l] = DS'(300000);
        endcase
    run_job(3, 2, 4, 1, 5, 0, 0);
    check("lit_relu_row", first_row[31:0], 32'h7F00_0102);
    run_job(3, 2, 4, 0, 5, 0, 0);
    check("lit_norelu_row", first_row[31:0], 32'h7FFF_0102);

    fill_random();
    rdy_mode = 1;
    run_job(5, 8, 2, 1, 0, 0, 0);
    rdy_mode = 0;
    run_job(0, 0, 0, 0, 1, 0, 0);
    run_job(7, 6, 1, 0, 9, 1, 0);

    run_job(2, 10, 0, 0, 0, 0, 3);
    run_job(2, 10, 5, 1, 13, 0, 0);

    for (int j = 0; j < 5; j++) begin
      fill_random();
      rdy_mode = 2;
      run_job($urandom_range(0, 15), $urandom_range(1, 16), $urandom_range(0, 19),
              1'($urandom_range(0, 1)), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
